// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Sequencing controller for a pipelined RISC-V datapath. It gates the PC and
// pipeline-register updates from a run enable, stalls on load-use hazards,
// squashes the wrong-path IF/ID instruction on a taken branch, and freezes the
// back half of the pipeline while a data-memory access is outstanding. A
// memory access that never completes is turned into a sticky error.
//
// Parameters
//   CNT_W        width of the saturating stall-cycle counter
//   MEM_TIMEOUT  wait cycles allowed for a memory access before ERROR
//                (0 disables the timeout)
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous, active-high reset
//   start_i         run enable; 0 parks the pipeline
//   ID_rs1_i        rs1 of the instruction in ID
//   ID_rs2_i        rs2 of the instruction in ID
//   ID_uses_rs2_i   ID instruction reads rs2
//   EX_rd_i         rd of the instruction in EX
//   EX_MemRead_i    EX instruction is a load
//   branch_taken_i  branch/jump in EX resolved taken
//   mem_req_i       MEM stage is accessing data memory this cycle
//   mem_ack_i       data memory completes the access this cycle
//   PCWrite_o       PC load enable
//   IFID_Write_o    IF/ID load enable
//   IFID_Flush_o    clear IF/ID to NOP
//   IDEX_Bubble_o   load NOP (controls zeroed) into ID/EX
//   Pipe_Hold_o     freeze ID/EX, EX/MEM and MEM/WB
//   state_o         0 IDLE, 1 RUN, 2 MEM_WAIT, 3 ERROR
//   stall_cnt_o     cycles with PCWrite_o=0 while in RUN or MEM_WAIT
//   err_o           sticky memory-timeout error
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_uses_rs2_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             EX_MemRead_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             Pipe_Hold_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } state_e;

  // The wait counter only has to reach MEM_TIMEOUT; it saturates beyond that,
  // which keeps it harmless when the timeout is disabled.
  localparam int                WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] TIMEOUT_V  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0]  wait_inc;
  logic               err_q, err_d;

  logic               load_use;
  logic               mem_stall;

  // Controls for normal flow (branch squash, load-use bubble, or advance).
  logic               flow_pc_write;
  logic               flow_ifid_write;
  logic               flow_ifid_flush;
  logic               flow_idex_bubble;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                    ((EX_rd_i == ID_rs1_i) ||
                     (ID_uses_rs2_i && (EX_rd_i == ID_rs2_i)));

  // An access acknowledged in the same cycle it is requested costs nothing.
  assign mem_stall = mem_req_i && !mem_ack_i;

  assign wait_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_ONE;

  // A taken branch wins over load-use: the stalled ID instruction is on the
  // wrong path and is flushed anyway.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    flow_pc_write    = 1'b1;
    flow_ifid_write  = 1'b1;
    flow_ifid_flush  = 1'b0;
    flow_idex_bubble = 1'b0;
    if (branch_taken_i) begin
      flow_ifid_flush  = 1'b1;
      flow_idex_bubble = 1'b1;
    end else if (load_use) begin
      flow_pc_write    = 1'b0;
      flow_ifid_write  = 1'b0;
      flow_idex_bubble = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Mealy outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;

    // Parked outputs: nothing advances and ID/EX is fed NOPs.
    PCWrite_o     = 1'b0;
    IFID_Write_o  = 1'b0;
    IFID_Flush_o  = 1'b0;
    IDEX_Bubble_o = 1'b1;
    Pipe_Hold_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end

      S_RUN: begin
        // An in-flight memory access must complete even if start_i drops.
        if (mem_stall) begin
          IDEX_Bubble_o = 1'b0;
          Pipe_Hold_o   = 1'b1;
          wait_cnt_d    = WAIT_ONE;
          if (TIMEOUT_EN && (WAIT_ONE >= TIMEOUT_V)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = S_MEM_WAIT;
          end
        end else if (!start_i) begin
          state_d = S_IDLE;
        end else begin
          PCWrite_o     = flow_pc_write;
          IFID_Write_o  = flow_ifid_write;
          IFID_Flush_o  = flow_ifid_flush;
          IDEX_Bubble_o = flow_idex_bubble;
        end
      end

      S_MEM_WAIT: begin
        if (!mem_ack_i) begin
          IDEX_Bubble_o = 1'b0;
          Pipe_Hold_o   = 1'b1;
          wait_cnt_d    = wait_inc;
          if (TIMEOUT_EN && (wait_inc >= TIMEOUT_V)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end else begin
          // The ack cycle already behaves like a RUN cycle.
          PCWrite_o     = flow_pc_write;
          IFID_Write_o  = flow_ifid_write;
          IFID_Flush_o  = flow_ifid_flush;
          IDEX_Bubble_o = flow_idex_bubble;
          state_d       = start_i ? S_RUN : S_IDLE;
        end
      end

      S_ERROR: begin
        // Parked until reset.
      end
    endcase
  end

  // Stall cycles are counted only while the pipeline is meant to be running.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !PCWrite_o &&
        (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Two instances share one stimulus stream:
//   inst 0: CNT_W=16, MEM_TIMEOUT=0 (timeout disabled, wide counter)
//   inst 1: CNT_W=3,  MEM_TIMEOUT=4 (timeout and saturation exercised)
// A behavioural model of the sequencing rules predicts every output each
// cycle. Inputs change 1 ns after the rising edge; outputs are compared at
// mid-cycle.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_memread, branch_taken, mem_req, mem_ack;

  logic        a_pc, a_ifw, a_flush, a_bubble, a_hold, a_err;
  logic [1:0]  a_state;
  logic [15:0] a_stall;
  logic        b_pc, b_ifw, b_flush, b_bubble, b_hold, b_err;
  logic [1:0]  b_state;
  logic [2:0]  b_stall;

  pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2), .ID_uses_rs2_i(id_uses_rs2),
    .EX_rd_i(ex_rd), .EX_MemRead_i(ex_memread), .branch_taken_i(branch_taken),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .PCWrite_o(a_pc), .IFID_Write_o(a_ifw), .IFID_Flush_o(a_flush),
    .IDEX_Bubble_o(a_bubble), .Pipe_Hold_o(a_hold),
    .state_o(a_state), .stall_cnt_o(a_stall), .err_o(a_err)
  );

  pipeline_hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2), .ID_uses_rs2_i(id_uses_rs2),
    .EX_rd_i(ex_rd), .EX_MemRead_i(ex_memread), .branch_taken_i(branch_taken),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .PCWrite_o(b_pc), .IFID_Write_o(b_ifw), .IFID_Flush_o(b_flush),
    .IDEX_Bubble_o(b_bubble), .Pipe_Hold_o(b_hold),
    .state_o(b_state), .stall_cnt_o(b_stall), .err_o(b_err)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. States: 0 idle, 1 run, 2 waiting on memory, 3 error.
  // ---------------------------------------------------------------------------
  localparam int IDLE = 0, RUN = 1, WAITING = 2, ERR = 3;

  int cnt_max [2] = '{65535, 7};
  int tmo     [2] = '{0, 4};

  int m_state [2];
  int m_stall [2];
  int m_wait  [2];
  bit m_err   [2];
  int n_state [2];
  int n_stall [2];
  int n_wait  [2];
  bit n_err   [2];
  logic [4:0] e_ctl [2];   // {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Hold}

  localparam logic [4:0] CTL_PARK  = 5'b00010;
  localparam logic [4:0] CTL_HOLD  = 5'b00001;
  localparam logic [4:0] CTL_GO    = 5'b11000;
  localparam logic [4:0] CTL_SQUSH = 5'b11110;
  localparam logic [4:0] CTL_BUBBL = 5'b00010;

  function automatic logic [4:0] flow_ctl();
    bit hz;
    hz = ex_memread && (ex_rd != 0) &&
         ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    if (branch_taken) return CTL_SQUSH;
    if (hz)           return CTL_BUBBL;
    return CTL_GO;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = IDLE; m_stall[k] = 0; m_wait[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_eval(input int k);
    e_ctl[k]   = CTL_PARK;
    n_state[k] = m_state[k];
    n_wait[k]  = m_wait[k];
    n_err[k]   = m_err[k];
    case (m_state[k])
      IDLE: if (start) n_state[k] = RUN;
      RUN: begin
        if (mem_req && !mem_ack) begin
          e_ctl[k]  = CTL_HOLD;
          n_wait[k] = 1;
          if (tmo[k] != 0 && 1 >= tmo[k]) begin n_state[k] = ERR; n_err[k] = 1'b1; end
          else n_state[k] = WAITING;
        end else if (!start) begin
          n_state[k] = IDLE;
        end else begin
          e_ctl[k] = flow_ctl();
        end
      end
      WAITING: begin
        if (!mem_ack) begin
          e_ctl[k]  = CTL_HOLD;
          n_wait[k] = m_wait[k] + 1;
          if (tmo[k] != 0 && n_wait[k] >= tmo[k]) begin n_state[k] = ERR; n_err[k] = 1'b1; end
        end else begin
          e_ctl[k]   = flow_ctl();
          n_state[k] = start ? RUN : IDLE;
        end
      end
      default: ;
    endcase
    n_stall[k] = m_stall[k];
    if ((m_state[k] == RUN || m_state[k] == WAITING) && !e_ctl[k][4])
      n_stall[k] = (m_stall[k] < cnt_max[k]) ? m_stall[k] + 1 : m_stall[k];
  endtask

  function automatic logic [4:0] obs_ctl(input int k);
    return (k == 0) ? {a_pc, a_ifw, a_flush, a_bubble, a_hold}
                    : {b_pc, b_ifw, b_flush, b_bubble, b_hold};
  endfunction

  // One clock: called 1 ns after a rising edge with inputs already driven.
  task automatic cycle();
    #4;
    for (int k = 0; k < 2; k++) begin
      model_eval(k);
      check($sformatf("ctl[%0d]", k), 32'(obs_ctl(k)), 32'(e_ctl[k]));
      check($sformatf("state[%0d]", k), (k == 0) ? 32'(a_state) : 32'(b_state), 32'(m_state[k]));
      check($sformatf("stall[%0d]", k), (k == 0) ? 32'(a_stall) : 32'(b_stall), 32'(m_stall[k]));
      check($sformatf("err[%0d]", k), (k == 0) ? 32'(a_err) : 32'(b_err), 32'(m_err[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_state[k] = n_state[k]; m_stall[k] = n_stall[k];
      m_wait[k]  = n_wait[k];  m_err[k]   = n_err[k];
    end
    #1;
  endtask

  task automatic drive(input bit st, input int rs1, input int rs2, input bit u2,
                       input int rd, input bit mr, input bit br, input bit rq, input bit ak);
    start = st; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs2 = u2;
    ex_rd = 5'(rd); ex_memread = mr; branch_taken = br; mem_req = rq; mem_ack = ak;
  endtask

  // Asserts reset between clock edges and checks the parked values appear
  // before the next edge; reset is released 1 ns after the following edge.
  task automatic do_async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_ctl_a", 32'({a_pc, a_ifw, a_flush, a_bubble, a_hold}), 32'(CTL_PARK));
    check("rst_ctl_b", 32'({b_pc, b_ifw, b_flush, b_bubble, b_hold}), 32'(CTL_PARK));
    check("rst_state_a", 32'(a_state), 32'd0);
    check("rst_state_b", 32'(b_state), 32'd0);
    check("rst_stall_a", 32'(a_stall), 32'd0);
    check("rst_err_b", 32'(b_err), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int stall_before;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle, then clean run.
    cycle();
    drive(1, 1, 2, 1, 3, 0, 0, 0, 0);
    repeat (6) cycle();

    // Load-use on rs1; rd=x0 (no stall); rs2 match unused (no stall); rs2 used.
    drive(1, 5, 0, 0, 5, 1, 0, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
    drive(1, 1, 6, 0, 6, 1, 0, 0, 0); cycle();
    drive(1, 1, 6, 1, 6, 1, 0, 0, 0); cycle();
    // Load-use together with a taken branch.
    drive(1, 7, 0, 0, 7, 1, 1, 0, 0); cycle();
    drive(1, 1, 2, 1, 3, 0, 0, 0, 0); cycle();

    // Memory access waiting three cycles, then acknowledged.
    stall_before = int'(a_stall);
    drive(1, 1, 2, 1, 3, 0, 0, 1, 0); repeat (3) cycle();
    mem_ack = 1'b1; cycle();
    check("mem_wait_stall_delta", 32'(int'(a_stall) - stall_before), 32'd3);
    check("mem_wait_back_to_run", 32'(a_state), 32'd1);
    drive(1, 1, 2, 1, 3, 0, 0, 0, 0); cycle();

    // start_i dropped during a wait: stays waiting until the ack.
    drive(1, 1, 2, 1, 3, 0, 0, 1, 0); cycle();
    start = 1'b0; repeat (2) cycle();
    mem_ack = 1'b1; cycle();
    check("drop_start_idle_after_ack", 32'(a_state), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // Never-acknowledged access: inst 1 times out, inst 0 keeps waiting.
    drive(1, 1, 2, 1, 3, 0, 0, 0, 0); cycle();
    mem_req = 1'b1; repeat (8) cycle();
    check("timeout_state_b", 32'(b_state), 32'd3);
    check("timeout_err_b", 32'(b_err), 32'd1);
    check("no_timeout_state_a", 32'(a_state), 32'd2);
    do_async_reset();

    // Error is sticky across start and acks until reset.
    drive(1, 1, 2, 1, 3, 0, 0, 1, 0); repeat (6) cycle();
    drive(1, 1, 2, 1, 3, 0, 0, 1, 1); repeat (3) cycle();
    check("err_sticky_b", 32'(b_err), 32'd1);
    do_async_reset();

    // Continuous load-use: the 3-bit counter saturates at 7.
    drive(1, 1, 2, 1, 3, 0, 0, 0, 0); cycle();
    drive(1, 9, 0, 0, 9, 1, 0, 0, 0); repeat (10) cycle();
    check("stall_saturate_b", 32'(b_stall), 32'd7);
    check("stall_count_a", 32'(a_stall), 32'd10);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_async_reset();
      end else begin
        drive($urandom_range(0, 9) != 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 15,
              $urandom_range(0, 99) < 20, 1'($urandom_range(0, 1)));
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the pipelined RISC-V datapath (PC, IF/ID, ID/EX, EX/MEM registers). Gates PC and pipeline-register updates from start_i, detects load-use hazards, squashes wrong-path instructions on taken branches, and freezes the pipeline while a data-memory access is outstanding. Sits beside Control; its outputs drive the PC write enable and the pipeline-register write/flush/bubble controls.

Parameters:
CNT_W, 16, width of the stall-cycle counter (saturating).
MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before error; 0 disables the timeout.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  run enable; 0 parks the pipeline
ID_rs1_i  in  5  rs1 of the instruction in ID
ID_rs2_i  in  5  rs2 of the instruction in ID
ID_uses_rs2_i  in  1  ID instruction reads rs2 (R-type/store/branch)
EX_rd_i  in  5  rd of the instruction in EX
EX_MemRead_i  in  1  EX instruction is a load
branch_taken_i  in  1  branch/jump in EX resolved taken
mem_req_i  in  1  MEM stage is accessing data memory this cycle
mem_ack_i  in  1  data memory completes the access this cycle
PCWrite_o  out  1  PC load enable
IFID_Write_o  out  1  IF/ID register load enable
IFID_Flush_o  out  1  clear IF/ID to NOP
IDEX_Bubble_o  out  1  load NOP (controls zeroed) into ID/EX
Pipe_Hold_o  out  1  freeze ID/EX, EX/MEM and MEM/WB
state_o  out  2  FSM state: 0 IDLE, 1 RUN, 2 MEM_WAIT, 3 ERROR
stall_cnt_o  out  CNT_W  cycles with PCWrite_o=0 while in RUN or MEM_WAIT, saturating
err_o  out  1  sticky memory-timeout error

Behaviour:
- Reset (asynchronous): state IDLE, stall_cnt_o=0, err_o=0, internal wait counter=0. Outputs take their IDLE values immediately.
- Outputs are combinational from state and the current inputs (Mealy); state, counters and err_o are registered.
- IDLE: PCWrite_o=0, IFID_Write_o=0, IFID_Flush_o=0, IDEX_Bubble_o=1, Pipe_Hold_o=0. start_i=1 moves to RUN next cycle.
- RUN, priority high to low:
  1. start_i=0: same outputs as IDLE, next state IDLE. Ignored if mem_req_i=1 and mem_ack_i=0; case 2 applies instead.
  2. Memory stall: mem_req_i=1 and mem_ack_i=0. PCWrite_o=0, IFID_Write_o=0, Pipe_Hold_o=1, Flush=0, Bubble=0. Next state MEM_WAIT, wait counter=1. If mem_ack_i=1 in the same cycle, no stall occurs.
  3. Branch taken: PCWrite_o=1 (target loads), IFID_Flush_o=1, IDEX_Bubble_o=1, IFID_Write_o=1.
  4. Load-use: EX_MemRead_i=1, EX_rd_i!=0, and EX_rd_i==ID_rs1_i or (ID_uses_rs2_i=1 and EX_rd_i==ID_rs2_i). PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1.
  5. Otherwise: PCWrite_o=1, IFID_Write_o=1, all other controls 0.
  - A branch in the same cycle as a load-use hazard takes the branch action, because the ID instruction is on the wrong path.
  - x0 never causes a hazard.
- MEM_WAIT: holds the case-2 outputs while mem_ack_i=0; the wait counter increments each cycle.
  - mem_ack_i=1: release. Outputs are evaluated with the RUN rules 3–5 that cycle, and the next state is RUN (or IDLE if start_i=0).
  - start_i is ignored until ack.
  - MEM_TIMEOUT!=0 and the wait counter reaches MEM_TIMEOUT with no ack: next state ERROR, err_o set.
- ERROR: IDLE outputs. Left only by rst_i. err_o stays 1.
- stall_cnt_o: increments by 1 on each clock where state is RUN or MEM_WAIT and PCWrite_o=0. Holds at 2^CNT_W−1. Not cleared by start_i.

Test Plan:
- Reset, start_i=1 from cycle 2, no hazards -> state_o 0→1; PCWrite_o=1 and IFID_Write_o=1 every RUN cycle; stall_cnt_o stays 0.
- RUN, EX_MemRead_i=1, EX_rd_i=5, ID_rs1_i=5 for 1 cycle -> that cycle PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1; stall_cnt_o=1. Repeat with EX_rd_i=0 -> no stall. Repeat with rs2 match and ID_uses_rs2_i=0 -> no stall.
- Load-use and branch_taken_i=1 in the same cycle -> PCWrite_o=1, IFID_Flush_o=1, IDEX_Bubble_o=1; stall_cnt_o unchanged.
- mem_req_i=1 with mem_ack_i low for 3 cycles, then high -> state_o 1,2,2,2,1. Pipe_Hold_o=1 for 3 cycles and 0 on the ack cycle; stall_cnt_o=3. start_i dropped mid-wait -> state is IDLE only after ack.
- MEM_TIMEOUT=4, mem_req_i=1, ack never -> err_o=1 and state_o=3 after the 4th wait cycle; remains so until rst_i. Assert rst_i asynchronously mid-MEM_WAIT -> outputs at IDLE values before the next clock edge.
- CNT_W=3, continuous load-use stall for 10 cycles -> stall_cnt_o saturates at 7.
